// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART receiver: line/enable inputs, byte strobe outputs, FSM state.
// Strobe semantics: rxd_flag and frame_err are single-clk pulses with no back-pressure (no ready);
// rxd_data is valid on the rxd_flag cycle and holds until the next good frame.
interface uart_rx_if;
  logic       clken_16bps;
  logic       rxd;
  logic [7:0] rxd_data;
  logic       rxd_flag;
  logic       frame_err;
  logic       rx_busy;
  logic [1:0] rx_state;

  modport slave (
    input  clken_16bps, rxd,
    output rxd_data, rxd_flag, frame_err, rx_busy, rx_state
  );

  modport master (
    output clken_16bps, rxd,
    input  rxd_data, rxd_flag, frame_err, rx_busy, rx_state
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// UART receiver: synchronises rxd, validates the start bit, samples 8 data bits LSB-first at
// bit centre using the 16x oversampling enable, and checks the stop bit.
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter bit MAJORITY    = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave rx
);
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } state_t;

  localparam logic [3:0] CENTRE_CNT = MAJORITY ? 4'd8 : 4'd7;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic                   smp6;
  logic                   smp7;
  logic                   decision;
  logic                   centre;
  logic [3:0]             smp_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic [7:0]             data_q;
  logic                   flag_q;
  logic                   err_q;

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx.rxd};
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    decision = rxd_s;
    if (MAJORITY) begin
      decision = (smp6 & smp7) | (smp6 & rxd_s) | (smp7 & rxd_s);
    end
    centre = rx.clken_16bps && (state != R_IDLE) && (smp_cnt == CENTRE_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= R_IDLE;
      smp_cnt <= 4'd0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      smp6    <= 1'b0;
      smp7    <= 1'b0;
      data_q  <= 8'h00;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
      if (rx.clken_16bps) begin
        if (state != R_IDLE) begin
          smp_cnt <= smp_cnt + 4'd1;
          if (smp_cnt == 4'd6) smp6 <= rxd_s;
          if (smp_cnt == 4'd7) smp7 <= rxd_s;
        end
        case (state)
          R_IDLE: begin
            smp_cnt <= 4'd0;
            if (!rxd_s) state <= R_START;
          end
          R_START: begin
            if (centre && decision) begin
              state   <= R_IDLE;
              smp_cnt <= 4'd0;
            end else if (smp_cnt == 4'd15) begin
              state   <= R_DATA;
              bit_cnt <= 3'd0;
            end
          end
          R_DATA: begin
            if (centre) shreg <= {decision, shreg[7:1]};
            if (smp_cnt == 4'd15) begin
              if (bit_cnt != 3'd7) bit_cnt <= bit_cnt + 3'd1;
              else                 state   <= R_STOP;
            end
          end
          R_STOP: begin
            // Leave at the stop centre so a start bit half a bit later is still caught.
            if (centre) begin
              state   <= R_IDLE;
              smp_cnt <= 4'd0;
              if (decision) begin
                data_q <= shreg;
                flag_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          default: state <= R_IDLE;
        endcase
      end
    end
  end

  assign rx.rxd_data  = data_q;
  assign rx.rxd_flag  = flag_q;
  assign rx.frame_err = err_q;
  assign rx.rx_busy   = (state != R_IDLE);
  assign rx.rx_state  = state;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: a majority-vote and a single-sample instance share one line,
// frames are driven per oversampling tick and strobes are scored against a frame-level model.
module tb_uart_rx_sampler;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clken = 1'b0;
  logic rxd   = 1'b1;

  int checks = 0;
  int errors = 0;

  // Entries are {is_frame_err, expected rxd_data}.
  logic [8:0] exp_q_maj[$];
  logic [8:0] exp_q_sgl[$];
  logic [7:0] last_maj = 8'h00;
  logic [7:0] last_sgl = 8'h00;

  always #5 clk = ~clk;

  uart_rx_if if_maj();
  uart_rx_if if_sgl();

  assign if_maj.clken_16bps = clken;
  assign if_maj.rxd         = rxd;
  assign if_sgl.clken_16bps = clken;
  assign if_sgl.rxd         = rxd;

  uart_rx_sampler #(.SYNC_STAGES(2), .MAJORITY(1'b1)) u_maj (.clk(clk), .rst_n(rst_n), .rx(if_maj));
  uart_rx_sampler #(.SYNC_STAGES(2), .MAJORITY(1'b0)) u_sgl (.clk(clk), .rst_n(rst_n), .rx(if_sgl));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: a low stop bit reports an error and keeps the old byte; a single
  // sampler takes a one-tick glitch at its sample point, the 3-way vote rejects it.
  function automatic logic [8:0] model(input logic [7:0] b, input logic stop, input int g,
                                       input bit majority, input logic [7:0] last);
    logic [7:0] d;
    d = b;
    if (!stop) return {1'b1, last};
    if (!majority && g >= 0 && g < 8) d[g] = ~d[g];
    return {1'b0, d};
  endfunction

  // One oversampling period: line value set at the tick start, enable in the middle.
  task automatic tick(input logic v);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) rxd = v;
      clken = (c == 8);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1);
  endtask

  // Glitch, when requested, lands on tick 8 of the data bit: sample 7 of that bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int g);
    repeat (16) tick(1'b0);
    for (int i = 0; i < 8; i++)
      for (int t = 0; t < 16; t++)
        tick((i == g && t == 8) ? ~b[i] : b[i]);
    repeat (16) tick(stop);
  endtask

  task automatic frame(input logic [7:0] b, input logic stop, input int g);
    logic [8:0] em;
    logic [8:0] es;
    em = model(b, stop, g, 1'b1, last_maj);
    es = model(b, stop, g, 1'b0, last_sgl);
    exp_q_maj.push_back(em);
    exp_q_sgl.push_back(es);
    if (!em[8]) last_maj = em[7:0];
    if (!es[8]) last_sgl = es[7:0];
    send_frame(b, stop, g);
  endtask

  // Scoreboard: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n) begin
      if (if_maj.rxd_flag || if_maj.frame_err) begin
        check("maj_exclusive", {31'd0, if_maj.rxd_flag & if_maj.frame_err}, 32'd0);
        e = (exp_q_maj.size() != 0) ? exp_q_maj.pop_front() : 9'bx;
        check("maj_strobe", {23'd0, if_maj.frame_err, if_maj.rxd_data}, {23'd0, e});
      end
      if (if_sgl.rxd_flag || if_sgl.frame_err) begin
        check("sgl_exclusive", {31'd0, if_sgl.rxd_flag & if_sgl.frame_err}, 32'd0);
        e = (exp_q_sgl.size() != 0) ? exp_q_sgl.pop_front() : 9'bx;
        check("sgl_strobe", {23'd0, if_sgl.frame_err, if_sgl.rxd_data}, {23'd0, e});
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic       stop;
    logic [8:0] e;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_data_maj", {24'd0, if_maj.rxd_data}, 32'h00);
    check("rst_flag_maj", {31'd0, if_maj.rxd_flag}, 32'd0);
    check("rst_err_maj", {31'd0, if_maj.frame_err}, 32'd0);
    check("rst_busy_maj", {31'd0, if_maj.rx_busy}, 32'd0);
    check("rst_busy_sgl", {31'd0, if_sgl.rx_busy}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Clean 0xA5, then 0x3C with a low stop bit
    frame(8'hA5, 1'b1, -1);
    idle(2);
    check("a5_data", {24'd0, if_maj.rxd_data}, 32'hA5);
    frame(8'h3C, 1'b0, -1);
    idle(20);
    check("err_hold_maj", {24'd0, if_maj.rxd_data}, 32'hA5);
    check("err_hold_sgl", {24'd0, if_sgl.rxd_data}, 32'hA5);

    // Back-to-back 0x00 then 0xFF
    frame(8'h00, 1'b1, -1);
    frame(8'hFF, 1'b1, -1);
    idle(2);
    check("b2b_data", {24'd0, if_maj.rxd_data}, 32'hFF);

    // False start: 4 low ticks
    repeat (4) tick(1'b0);
    repeat (2) tick(1'b1);
    check("false_start_busy", {31'd0, if_maj.rx_busy}, 32'd1);
    repeat (4) tick(1'b1);
    check("false_start_idle_maj", {31'd0, if_maj.rx_busy}, 32'd0);
    check("false_start_idle_sgl", {31'd0, if_sgl.rx_busy}, 32'd0);
    idle(2);

    // 0x55 with a one-tick glitch on D2
    frame(8'h55, 1'b1, 2);
    idle(2);
    check("glitch_maj", {24'd0, if_maj.rxd_data}, 32'h55);
    check("glitch_sgl", {24'd0, if_sgl.rxd_data}, 32'h51);

    // Reset in the middle of D4 of 0x96
    b = 8'h96;
    repeat (16) tick(1'b0);
    for (int i = 0; i < 4; i++) repeat (16) tick(b[i]);
    repeat (8) tick(b[4]);
    check("mid_busy_before_rst", {31'd0, if_maj.rx_busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_busy", {31'd0, if_maj.rx_busy}, 32'd0);
    check("mid_rst_data", {24'd0, if_sgl.rxd_data}, 32'h00);
    rst_n    = 1'b1;
    last_maj = 8'h00;
    last_sgl = 8'h00;
    idle(2);
    frame(8'h96, 1'b1, -1);
    idle(2);
    check("post_rst_data", {24'd0, if_maj.rxd_data}, 32'h96);

    // Break: line low for two full receive cycles (153 ticks to the stop centre, then
    // restart on the next tick) yields two framing errors.
    for (int k = 0; k < 2; k++) begin
      e = model(8'h00, 1'b0, -1, 1'b1, last_maj);
      exp_q_maj.push_back(e);
      e = model(8'h00, 1'b0, -1, 1'b0, last_sgl);
      exp_q_sgl.push_back(e);
    end
    repeat (308) tick(1'b0);
    idle(20);
    check("break_idle", {31'd0, if_maj.rx_busy}, 32'd0);

    // Randomised frames
    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      frame(b, stop, -1);
      if (stop) idle($urandom_range(0, 3));
      else      idle(20);
    end

    idle(20);
    check("maj_queue_drained", exp_q_maj.size(), 32'd0);
    check("sgl_queue_drained", exp_q_sgl.size(), 32'd0);
    check("final_busy", {31'd0, if_sgl.rx_busy}, 32'd0);
    check("final_data_maj", {24'd0, if_maj.rxd_data}, {24'd0, last_maj});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
